// File: rtl/conv1d_pkg.sv
// rtl/conv1d_pkg.sv - shared offsets, FSM states, OBI structs and saturation helper for conv1d
// Purpose: common declarations imported by user_conv1d_obi_sbr and conv1d_mac_dp.
// Ports: none (package).
package conv1d_pkg;

  // Byte offsets inside the 64 KiB window
  localparam logic [15:0] OFF_CTRL   = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0004;
  localparam logic [15:0] OFF_LEN    = 16'h0008;
  localparam logic [15:0] OFF_COEF   = 16'h0010;
  localparam logic [15:0] OFF_XBUF   = 16'h0400;
  localparam logic [15:0] OFF_YBUF   = 16'h0800;

  localparam logic signed [63:0] SAT_MAX = 64'sd2147483647;
  localparam logic signed [63:0] SAT_MIN = -64'sd2147483648;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_MAC,
    ST_STORE,
    ST_FIN
  } conv1d_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } conv1d_obi_a_t;

  typedef struct packed {
    logic          req;
    conv1d_obi_a_t a;
  } conv1d_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } conv1d_obi_r_t;

  typedef struct packed {
    logic          gnt;
    logic          rvalid;
    conv1d_obi_r_t r;
  } conv1d_obi_rsp_t;

  // Clamp a signed value into int32 range
  function automatic logic [31:0] sat32(input logic signed [63:0] v);
    if (v > SAT_MAX) return 32'h7FFF_FFFF;
    if (v < SAT_MIN) return 32'h8000_0000;
    return v[31:0];
  endfunction

endpackage

// File: rtl/conv1d_mac_dp.sv
// rtl/conv1d_mac_dp.sv - signed multiply-accumulate with int32 saturated view
// Purpose: one product per cycle into a wide accumulator.
// Ports: clk_i/rst_ni clock and async active-low reset; clr zeroes the accumulator
//        (wins over en); en adds a*b; acc_o raw accumulator; sat_o acc_o clamped to int32.
module conv1d_mac_dp
  import conv1d_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int AccWidth  = 35
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [DataWidth-1:0] a,
  input  logic signed [DataWidth-1:0] b,
  output logic signed [AccWidth-1:0]  acc_o,
  output logic [31:0]                 sat_o
);

  logic signed [2*DataWidth-1:0] prod;
  logic signed [AccWidth-1:0]    acc_d, acc_q;

  always_comb begin
    prod  = (2*DataWidth)'(a) * (2*DataWidth)'(b);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + AccWidth'(prod);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;
  assign sat_o = sat32(64'(acc_q));

endmodule

// File: rtl/user_conv1d_obi_sbr.sv
// rtl/user_conv1d_obi_sbr.sv - OBI subordinate computing a valid-mode 1D convolution
// Purpose: register/buffer map over OBI plus a one-MAC-per-cycle sequencer.
// Ports: clk_i clock; rst_ni async active-low reset; obi_req_i/obi_rsp_o OBI
//        subordinate (gnt combinational, response one cycle later); irq_o = DONE & IRQ_EN.
module user_conv1d_obi_sbr
  import conv1d_pkg::*;
#(
  parameter int  NumTaps   = 4,
  parameter int  BufDepth  = 32,
  parameter int  DataWidth = 16,
  parameter type obi_req_t = conv1d_obi_req_t,
  parameter type obi_rsp_t = conv1d_obi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output logic     irq_o
);

  localparam int AW       = $clog2(BufDepth);
  localparam int LW       = AW + 1;
  localparam int KW       = (NumTaps > 1) ? $clog2(NumTaps) : 1;
  localparam int AccWidth = 2*DataWidth + $clog2(NumTaps) + 1;

  conv1d_state_e               state_q, state_d;
  logic                        irq_en_q, irq_en_d, done_q, done_d;
  logic [LW-1:0]               len_q, len_d;
  logic [AW-1:0]               i_q, i_d;
  logic [KW-1:0]               k_q, k_d;
  logic signed [DataWidth-1:0] coef_q [NumTaps];
  logic signed [DataWidth-1:0] coef_d [NumTaps];
  logic signed [DataWidth-1:0] xbuf_q [BufDepth];
  logic signed [DataWidth-1:0] xbuf_d [BufDepth];
  logic [31:0]                 ybuf_q [BufDepth];
  logic [31:0]                 ybuf_d [BufDepth];
  obi_rsp_t                    rsp_q, rsp_d;

  logic                        busy, dp_clr, dp_en;
  logic [15:0]                 off;
  logic                        sel_ctrl, sel_status, sel_len, sel_coef, sel_xbuf, sel_ybuf;
  logic [KW-1:0]               coef_idx;
  logic [AW-1:0]               buf_idx, xi;
  logic signed [AccWidth-1:0]  acc;
  logic [31:0]                 sat;
  logic [31:0]                 wdata;
  logic                        unused_ok;

  assign busy       = (state_q != ST_IDLE);
  assign wdata      = obi_req_i.a.wdata;
  // Byte lanes and sub-word address bits carry no meaning: every access is a full word
  assign off        = {obi_req_i.a.addr[15:2], 2'b00};
  assign sel_ctrl   = (off == OFF_CTRL);
  assign sel_status = (off == OFF_STATUS);
  assign sel_len    = (off == OFF_LEN);
  assign sel_coef   = (off >= OFF_COEF) && (off < OFF_COEF + 16'(4*NumTaps));
  assign sel_xbuf   = (off >= OFF_XBUF) && (off < OFF_XBUF + 16'(4*BufDepth));
  assign sel_ybuf   = (off >= OFF_YBUF) && (off < OFF_YBUF + 16'(4*BufDepth));
  assign coef_idx   = KW'((off - OFF_COEF) >> 2);
  assign buf_idx    = off[AW+1:2];
  assign xi         = i_q + AW'(k_q);
  assign unused_ok  = ^{obi_req_i.a.addr[31:16], obi_req_i.a.addr[1:0], obi_req_i.a.be, acc};

  conv1d_mac_dp #(
    .DataWidth(DataWidth),
    .AccWidth (AccWidth)
  ) u_mac_dp (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr   (dp_clr),
    .en    (dp_en),
    .a     (coef_q[k_q]),
    .b     (xbuf_q[xi]),
    .acc_o (acc),
    .sat_o (sat)
  );

  always_comb begin
    state_d  = state_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    len_d    = len_q;
    i_d      = i_q;
    k_d      = k_q;
    coef_d   = coef_q;
    xbuf_d   = xbuf_q;
    ybuf_d   = ybuf_q;
    dp_clr   = 1'b0;
    dp_en    = 1'b0;
    rsp_d          = '0;
    rsp_d.rvalid   = obi_req_i.req;
    rsp_d.r.rid    = obi_req_i.a.aid;

    // Bus side first so that the sequencer's DONE set below overrides a same-cycle W1C
    if (obi_req_i.req) begin
      if (obi_req_i.a.we) begin
        if (sel_ctrl) begin
          irq_en_d = wdata[1];
          if (wdata[0] && !busy) begin
            state_d = ST_CHECK;
            done_d  = 1'b0;
          end
        end else if (sel_status) begin
          if (wdata[1]) done_d = 1'b0;
        end else if (busy && (sel_len || sel_coef || sel_xbuf)) begin
          rsp_d.r.err = 1'b1;
        end else if (sel_len) begin
          len_d = (wdata > 32'(BufDepth)) ? LW'(BufDepth) : wdata[LW-1:0];
        end else if (sel_coef) begin
          coef_d[coef_idx] = wdata[DataWidth-1:0];
        end else if (sel_xbuf) begin
          xbuf_d[buf_idx] = wdata[DataWidth-1:0];
        end else begin
          rsp_d.r.err = 1'b1;  // YBUF is read-only, everything else is unmapped
        end
      end else begin
        if (sel_ctrl)        rsp_d.r.rdata = {30'b0, irq_en_q, 1'b0};
        else if (sel_status) rsp_d.r.rdata = {30'b0, done_q, busy};
        else if (sel_len)    rsp_d.r.rdata = 32'(len_q);
        else if (sel_coef)   rsp_d.r.rdata = 32'(coef_q[coef_idx]);
        else if (sel_xbuf)   rsp_d.r.rdata = 32'(xbuf_q[buf_idx]);
        else if (sel_ybuf)   rsp_d.r.rdata = ybuf_q[buf_idx];
        else                 rsp_d.r.err   = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: ;
      ST_CHECK: begin
        if (len_q < LW'(NumTaps)) begin
          state_d = ST_FIN;
        end else begin
          i_d     = '0;
          k_d     = '0;
          dp_clr  = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        dp_en = 1'b1;
        if (k_q == KW'(NumTaps - 1)) state_d = ST_STORE;
        else                         k_d = k_q + 1'b1;
      end
      ST_STORE: begin
        ybuf_d[i_q] = sat;
        dp_clr      = 1'b1;
        k_d         = '0;
        if ({1'b0, i_q} == len_q - LW'(NumTaps)) begin
          state_d = ST_FIN;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      len_q    <= '0;
      i_q      <= '0;
      k_q      <= '0;
      coef_q   <= '{default: '0};
      xbuf_q   <= '{default: '0};
      ybuf_q   <= '{default: '0};
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      len_q    <= len_d;
      i_q      <= i_d;
      k_q      <= k_d;
      coef_q   <= coef_d;
      xbuf_q   <= xbuf_d;
      ybuf_q   <= ybuf_d;
      rsp_q    <= rsp_d;
    end
  end

  always_comb begin
    obi_rsp_o     = rsp_q;
    obi_rsp_o.gnt = obi_req_i.req;
  end

  assign irq_o = done_q & irq_en_q;

endmodule

// File: tb/tb_user_conv1d_obi_sbr.sv
// tb/tb_user_conv1d_obi_sbr.sv - randomized self-checking bench for user_conv1d_obi_sbr
module tb_user_conv1d_obi_sbr;
  import conv1d_pkg::*;

  localparam int K = 4;
  localparam int D = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic            clk;
  logic            rst_n;
  logic            irq;
  conv1d_obi_req_t req;
  conv1d_obi_rsp_t rsp;

  int          n_chk = 0;
  int          n_err = 0;
  int          coef_m [K];
  int          x_m [D];
  logic [31:0] y_m [D];
  int          len_m;
  int          cyc;

  user_conv1d_obi_sbr dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .obi_req_i(req),
    .obi_rsp_o(rsp),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sext16(input int v);
    int t;
    t = v & 'hFFFF;
    if (t >= 32768) t -= 65536;
    return t;
  endfunction

  task automatic xfer(input logic we, input logic [15:0] a, input logic [31:0] d,
                      output logic [31:0] rdata, output logic err);
    logic [3:0] id;
    id = 4'($urandom);
    @(negedge clk);
    req.req     = 1'b1;
    req.a.addr  = {16'h2001, a};
    req.a.we    = we;
    req.a.be    = 4'hF;
    req.a.wdata = d;
    req.a.aid   = id;
    #1 check("gnt", 32'(rsp.gnt), 32'd1);
    @(posedge clk);
    #1;
    req.req = 1'b0;
    check("rvalid", 32'(rsp.rvalid), 32'd1);
    check("rid", 32'(rsp.r.rid), 32'(id));
    rdata = rsp.r.rdata;
    err   = rsp.r.err;
  endtask

  task automatic wr(input string tag, input logic [15:0] a, input logic [31:0] d, input logic exp_err);
    logic [31:0] rd_v;
    logic        e;
    xfer(1'b1, a, d, rd_v, e);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
    check({tag, "_wdata0"}, rd_v, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp, input logic exp_err);
    logic [31:0] rd_v;
    logic        e;
    xfer(1'b0, a, 32'd0, rd_v, e);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
    check(tag, rd_v, exp_err ? 32'd0 : exp);
  endtask

  // Behavioural reference: direct sum of products, clamped to int32
  task automatic run_model();
    longint s;
    for (int i = 0; i + K <= len_m; i++) begin
      s = 0;
      for (int k = 0; k < K; k++) s += longint'(coef_m[k]) * longint'(x_m[i+k]);
      if (s > SMAX) s = SMAX;
      if (s < SMIN) s = SMIN;
      y_m[i] = 32'(s);
    end
  endtask

  function automatic int exp_lat();
    return (len_m >= K) ? (len_m - K + 1) * (K + 1) + 2 : 2;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < K; k++) coef_m[k] = 0;
    for (int i = 0; i < D; i++) begin
      x_m[i] = 0;
      y_m[i] = '0;
    end
    len_m = 0;
  endtask

  task automatic load_all();
    for (int k = 0; k < K; k++) wr("ld_coef", 16'(16 + 4*k), 32'(coef_m[k]), 1'b0);
    for (int i = 0; i < D; i++) wr("ld_x", 16'(1024 + 4*i), 32'(x_m[i]), 1'b0);
  endtask

  task automatic check_ybuf();
    for (int i = 0; i < D; i++) rd("ybuf", 16'(2048 + 4*i), y_m[i], 1'b0);
  endtask

  task automatic wait_irq(input int budget, output int cycles);
    cycles = 0;
    while (!irq && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic start_and_wait(input string tag);
    int c;
    wr("start", 16'h0000, 32'd3, 1'b0);
    wait_irq(1000, c);
    check({tag, "_latency"}, 32'(c), 32'(exp_lat()));
    run_model();
  endtask

  task automatic scenario1();
    for (int k = 0; k < K; k++) coef_m[k] = k + 1;
    for (int i = 0; i < D; i++) x_m[i] = (i < 6) ? i + 1 : 0;
    load_all();
    len_m = 6;
    wr("len6", 16'h0008, 32'd6, 1'b0);
    start_and_wait("s1");
    rd("s1_y0", 16'h0800, 32'd30, 1'b0);
    rd("s1_y1", 16'h0804, 32'd40, 1'b0);
    rd("s1_y2", 16'h0808, 32'd50, 1'b0);
    check_ybuf();
    rd("s1_status", 16'h0004, 32'd2, 1'b0);
    check("s1_irq_en", 32'(irq), 32'd1);
  endtask

  initial begin
    int lw;
    logic [31:0] v;
    logic        e;
    req   = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check("rst_irq", 32'(irq), 32'd0);
    check("rst_rvalid", 32'(rsp.rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("rst_ctrl", 16'h0000, 32'd0, 1'b0);
    rd("rst_status", 16'h0004, 32'd0, 1'b0);
    rd("rst_len", 16'h0008, 32'd0, 1'b0);
    rd("rst_y5", 16'h0814, 32'd0, 1'b0);
    rd("unmap_0c", 16'h000C, 32'd0, 1'b1);
    rd("unmap_coef4", 16'h0020, 32'd0, 1'b1);
    rd("unmap_x32", 16'h0480, 32'd0, 1'b1);
    wr("unmap_wr", 16'h1000, 32'd5, 1'b1);

    scenario1();
    wr("irq_off", 16'h0000, 32'd0, 1'b0);
    check("irq_masked", 32'(irq), 32'd0);
    rd("s1_status2", 16'h0004, 32'd2, 1'b0);
    wr("irq_on", 16'h0000, 32'd2, 1'b0);
    check("irq_unmasked", 32'(irq), 32'd1);

    // N < K: no outputs touched
    len_m = 3;
    wr("len3", 16'h0008, 32'd3, 1'b0);
    start_and_wait("s2");
    check_ybuf();

    // Saturation both ways
    for (int k = 0; k < K; k++) coef_m[k] = 32767;
    for (int i = 0; i < D; i++) x_m[i] = 32767;
    load_all();
    len_m = 4;
    wr("len4", 16'h0008, 32'd4, 1'b0);
    start_and_wait("s3p");
    rd("sat_pos", 16'h0800, 32'h7FFF_FFFF, 1'b0);
    for (int k = 0; k < K; k++) begin
      coef_m[k] = -32768;
      wr("ld_coef_neg", 16'(16 + 4*k), 32'h0000_8000, 1'b0);
    end
    rd("coef_sext", 16'h0010, 32'hFFFF_8000, 1'b0);
    start_and_wait("s3n");
    rd("sat_neg", 16'h0800, 32'h8000_0000, 1'b0);
    wr("len_clamp_wr", 16'h0008, 32'd100, 1'b0);
    rd("len_clamp", 16'h0008, 32'd32, 1'b0);

    // Random runs; the first is long and gets poked while busy
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < K; k++) coef_m[k] = sext16(int'($urandom));
      for (int i = 0; i < D; i++) x_m[i] = sext16(int'($urandom));
      lw = (r == 0) ? 32 : int'($urandom_range(0, 40));
      len_m = (lw > D) ? D : lw;
      load_all();
      wr("len_rand", 16'h0008, 32'(lw), 1'b0);
      wr("start", 16'h0000, 32'd3, 1'b0);
      if (r == 0) begin
        wr("busy_x0", 16'h0400, 32'(x_m[0]) ^ 32'h0000_1234, 1'b1);
        wr("busy_len", 16'h0008, 32'd5, 1'b1);
        wr("busy_coef", 16'h0010, 32'd7, 1'b1);
        wr("busy_ybuf", 16'h0800, 32'd9, 1'b1);
        wr("busy_start", 16'h0000, 32'd3, 1'b0);
        rd("busy_status", 16'h0004, 32'd1, 1'b0);
        rd("busy_0c", 16'h000C, 32'd0, 1'b1);
        rd("busy_x0_rb", 16'h0400, 32'(x_m[0]), 1'b0);
        @(negedge clk);
        req.req = 1'b1; req.a.we = 1'b0; req.a.addr = 32'h2001_0004; req.a.aid = 4'h5;
        @(posedge clk);
        #1 check("b2b_rv0", 32'(rsp.rvalid), 32'd1);
        check("b2b_rid0", 32'(rsp.r.rid), 32'h5);
        check("b2b_st", rsp.r.rdata, 32'd1);
        req.a.addr = 32'h2001_0008; req.a.aid = 4'hA;
        @(posedge clk);
        #1 check("b2b_rv1", 32'(rsp.rvalid), 32'd1);
        check("b2b_rid1", 32'(rsp.r.rid), 32'hA);
        check("b2b_len", rsp.r.rdata, 32'd32);
        req.req = 1'b0;
        @(posedge clk);
        #1 check("b2b_idle", 32'(rsp.rvalid), 32'd0);
        wait_irq(1000, cyc);
        check("busy_run_done", 32'(irq), 32'd1);
      end else begin
        wait_irq(1000, cyc);
        check("rand_latency", 32'(cyc), 32'(exp_lat()));
      end
      run_model();
      check_ybuf();
      rd("len_rb", 16'h0008, 32'(len_m), 1'b0);
      rd("coef_rb", 16'h001C, 32'(coef_m[3]), 1'b0);
    end

    // W1C lands in the FIN cycle: set wins
    len_m = 2;
    wr("len2", 16'h0008, 32'd2, 1'b0);
    wr("start", 16'h0000, 32'd3, 1'b0);
    @(posedge clk);
    wr("w1c_fin", 16'h0004, 32'd2, 1'b0);
    rd("done_kept", 16'h0004, 32'd2, 1'b0);
    check("irq_kept", 32'(irq), 32'd1);
    wr("w1c", 16'h0004, 32'd2, 1'b0);
    rd("done_clr", 16'h0004, 32'd0, 1'b0);
    check("irq_clr", 32'(irq), 32'd0);

    // Reset mid-run
    len_m = 10;
    wr("len10", 16'h0008, 32'd10, 1'b0);
    wr("start", 16'h0000, 32'd3, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_rvalid", 32'(rsp.rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rd("mid_rst_status", 16'h0004, 32'd0, 1'b0);
    rd("mid_rst_len", 16'h0008, 32'd0, 1'b0);
    rd("mid_rst_ctrl", 16'h0000, 32'd0, 1'b0);
    rd("mid_rst_x0", 16'h0400, 32'd0, 1'b0);
    check_ybuf();
    xfer(1'b0, 16'h0004, 32'd0, v, e);
    check("mid_rst_busy", v, 32'd0);
    scenario1();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
